pipe_fetch_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage CPU.
- Decides each cycle whether the fetch stage advances PC, whether the IF/ID register captures, and whether IF/ID or ID/EX are flushed to bubbles.
- Handles load-use stalls, taken-branch and jump flushes, a post-reset boot hold, and a halt/drain handshake used by the debug loader.
- Sits beside the fetch stage; its pc_we and fd_flush outputs gate the PC/IR registers and the bnoWB/jnoWB-style kill path.

---
 rtl/pipe_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_fetch_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-side sequencing for the 5-stage pipeline: PC/IF-ID write enables, bubble
// injection for load-use, branch/jump redirects, boot hold and debug halt/drain.
//
// state  | meaning
// BOOT   | PC held while instruction memory is preloaded
// RUN    | normal issue with stall/flush arbitration
// DRAIN  | PC frozen, bubbles pushed into ID until the pipe is empty
// HALTED | pipeline frozen, halt_ack high until halt_req drops
module pipe_fetch_ctrl #(
    parameter int BOOT_CYCLES  = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rt,
    input  logic [4:0]       dx_rt,
    input  logic             dx_memread,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] boot_cnt;
    logic [3:0] drain_cnt;
    logic       lu;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = dx_memread && (dx_rt != 5'd0) &&
                ((dx_rt == fd_rs) || (fd_uses_rt && (dx_rt == fd_rt)));

    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        case (state)
            BOOT: begin
                fd_flush = 1'b1;
                dx_flush = 1'b1;
            end
            RUN: begin
                if (br_taken) begin
                    pc_we    = 1'b1;
                    fd_we    = 1'b1;
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (lu) begin
                    dx_flush = 1'b1;
                end else if (jump) begin
                    pc_we    = 1'b1;
                    fd_we    = 1'b1;
                    fd_flush = 1'b1;
                end else begin
                    pc_we = 1'b1;
                    fd_we = 1'b1;
                end
            end
            DRAIN: begin
                fd_we    = 1'b1;
                fd_flush = 1'b1;
                if (br_taken) begin
                    pc_we    = 1'b1;
                    dx_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            boot_cnt  <= 8'd0;
            drain_cnt <= 4'd0;
            halt_ack  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == 8'(BOOT_CYCLES - 1)) begin
                        state <= RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (br_taken || (!lu && jump)) begin
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                    end else if (lu) begin
                        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                    end else if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= 4'd0;
                    end
                end
                DRAIN: begin
                    // A late branch refills the front end, so the drain starts over.
                    if (br_taken) begin
                        drain_cnt <= 4'd0;
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                    end else if (drain_cnt == 4'(DRAIN_CYCLES - 1)) begin
                        state    <= HALTED;
                        halt_ack <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl: boot hold, load-use, redirect priority,
// halt/drain handshake, branch during drain and counter saturation.
module tb_pipe_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  fd_rs = '0, fd_rt = '0, dx_rt = '0;
    logic        fd_uses_rt = 1'b0, dx_memread = 1'b0;
    logic        br_taken = 1'b0, jump = 1'b0, halt_req = 1'b0;
    logic        pc_we, fd_we, fd_flush, dx_flush, halt_ack;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_we, s_fd_we, s_fd_flush, s_dx_flush, s_halt_ack;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_fetch_ctrl dut (
        .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
        .dx_rt(dx_rt), .dx_memread(dx_memread), .br_taken(br_taken), .jump(jump),
        .halt_req(halt_req), .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush),
        .dx_flush(dx_flush), .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_fetch_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
        .dx_rt(dx_rt), .dx_memread(dx_memread), .br_taken(br_taken), .jump(jump),
        .halt_req(halt_req), .pc_we(s_pc_we), .fd_we(s_fd_we), .fd_flush(s_fd_flush),
        .dx_flush(s_dx_flush), .halt_ack(s_halt_ack), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational controls as one nibble {pc_we, fd_we, fd_flush, dx_flush}.
    function automatic logic [31:0] ctl();
        return {28'd0, pc_we, fd_we, fd_flush, dx_flush};
    endfunction

    task automatic clear_in();
        fd_rs = '0; fd_rt = '0; dx_rt = '0; fd_uses_rt = 0; dx_memread = 0;
        br_taken = 0; jump = 0;
    endtask

    int low_cnt;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", ctl(), 32'b0011);
        chk("reset_ack", halt_ack, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_flush", flush_cnt, 0);

        rst = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!pc_we) low_cnt++;
            tick();
        end
        chk("boot_hold_cycles", low_cnt, 8);
        chk("boot_run_ctl", ctl(), 32'b1100);
        chk("boot_ack", halt_ack, 0);

        // load-use on rs
        dx_memread = 1; dx_rt = 5; fd_rs = 5; #1;
        chk("lu_rs_ctl", ctl(), 32'b0001);
        tick(); clear_in(); #1;
        chk("lu_rs_after_ctl", ctl(), 32'b1100);
        chk("lu_rs_stall", stall_cnt, 1);

        // load-use on rt, then same rt without fd_uses_rt
        dx_memread = 1; dx_rt = 7; fd_rt = 7; fd_rs = 3; fd_uses_rt = 1; #1;
        chk("lu_rt_ctl", ctl(), 32'b0001);
        fd_uses_rt = 0; #1;
        chk("lu_rt_unused_ctl", ctl(), 32'b1100);
        fd_uses_rt = 1;
        tick(); clear_in(); #1;
        chk("lu_rt_stall", stall_cnt, 2);

        // register 0 never stalls
        dx_memread = 1; dx_rt = 0; fd_rs = 0; #1;
        chk("lu_r0_ctl", ctl(), 32'b1100);
        tick(); clear_in(); #1;
        chk("lu_r0_stall", stall_cnt, 2);

        jump = 1; #1;
        chk("jump_ctl", ctl(), 32'b1110);
        tick(); clear_in(); #1;
        chk("jump_flush", flush_cnt, 1);

        // branch beats load-use and jump
        br_taken = 1; jump = 1; dx_memread = 1; dx_rt = 5; fd_rs = 5; #1;
        chk("br_prio_ctl", ctl(), 32'b1111);
        tick(); clear_in(); #1;
        chk("br_prio_flush", flush_cnt, 2);
        chk("br_prio_stall", stall_cnt, 2);

        // halt handshake
        halt_req = 1; #1;
        chk("halt_entry_ctl", ctl(), 32'b1100);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("drain_ctl", ctl(), 32'b0110);
            chk("drain_ack", halt_ack, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("halted_ack", halt_ack, 1);
            chk("halted_ctl", ctl(), 32'b0000);
            tick();
        end
        halt_req = 0; #1;
        chk("halted_release_ack", halt_ack, 1);
        tick();
        chk("resume_ack", halt_ack, 0);
        chk("resume_ctl", ctl(), 32'b1100);

        // halt coinciding with jump is deferred one cycle
        halt_req = 1; jump = 1; #1;
        chk("halt_jump_ctl", ctl(), 32'b1110);
        tick(); jump = 0; #1;
        chk("halt_deferred_ctl", ctl(), 32'b1100);
        tick();
        chk("dr0_ctl", ctl(), 32'b0110);
        tick();
        chk("dr1_ctl", ctl(), 32'b0110);
        tick();
        br_taken = 1; #1;
        chk("drain_br_ctl", ctl(), 32'b1111);
        tick(); br_taken = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("redrain_ctl", ctl(), 32'b0110);
            chk("redrain_ack", halt_ack, 0);
            tick();
        end
        chk("redrain_halted_ack", halt_ack, 1);
        chk("drain_br_flush", flush_cnt, 4);
        halt_req = 0;
        tick();
        chk("resume2_ack", halt_ack, 0);

        // saturation on the narrow instance
        for (int i = 0; i < 20; i++) begin
            dx_memread = 1; dx_rt = 9; fd_rs = 9;
            tick(); clear_in();
            tick();
        end
        chk("stall_wide", stall_cnt, 22);
        chk("stall_sat", s_stall_cnt, 15);
        chk("flush_narrow", s_flush_cnt, 4);

        // asynchronous reset mid-run
        #2 rst = 0; #1;
        chk("midreset_ctl", ctl(), 32'b0011);
        chk("midreset_stall", stall_cnt, 0);
        chk("midreset_flush", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
